dvp_frame_tx: RTL and testbench



---
 rtl/dvp_pkg.sv | 22 ++
 rtl/dvp_word_serializer.sv | 39 +++
 rtl/dvp_frame_tx.sv | 154 +++++++++++++++
 tb/tb_dvp_frame_tx.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dvp_pkg.sv
// Shared types and constants for the DVP frame transmitter.
package dvp_pkg;

    typedef enum logic [2:0] {
        IDLE,
        VSYNC,
        VBACK,
        ACTIVE,
        VFRONT
    } dvp_state_e;

    localparam int BYTES_PER_WORD = 8;

    // Bytes leave the 64-bit word starting at bits [63:56].
    localparam bit MSB_FIRST = 1'b1;

    // Clocks per line: two bytes per RGB565 pixel plus the href-low gap.
    function automatic int line_total(input int h_active, input int h_blank);
        return 2 * h_active + h_blank;
    endfunction

endpackage

// File: rtl/dvp_word_serializer.sv
// Holds the prefetched FIFO word and the byte shift register feeding dvp_data.
module dvp_word_serializer
    import dvp_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        capture_i,
    input  logic        zero_i,
    input  logic        load_i,
    input  logic        shift_i,
    input  logic [63:0] word_i,
    input  logic        href_i,
    output logic [7:0]  data_o
);

    logic [63:0] next_word_q;
    logic [63:0] shift_q;

    // Capture the returned FIFO word (or zeros on underflow), then load and shift it out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            next_word_q <= '0;
            shift_q     <= '0;
        end else begin
            if (capture_i) begin
                next_word_q <= zero_i ? 64'h0 : word_i;
            end
            if (load_i) begin
                shift_q <= next_word_q;
            end else if (shift_i) begin
                shift_q <= MSB_FIRST ? (shift_q << 8) : (shift_q >> 8);
            end
        end
    end

    // Data is forced to zero outside the active part of a line.
    assign data_o = !href_i ? 8'h00 : (MSB_FIRST ? shift_q[63:56] : shift_q[7:0]);

endmodule

// File: rtl/dvp_frame_tx.sv
// Frame/line timing FSM that replays 64-bit RGB565 words as a DVP byte stream.
module dvp_frame_tx
    import dvp_pkg::*;
#(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int H_BLANK     = 160,
    parameter int VSYNC_LINES = 4,
    parameter int V_BACK      = 16,
    parameter int V_FRONT     = 10,
    parameter int HW          = 12,
    parameter int VW          = 11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        fifo_empty,
    input  logic [63:0] fifo_rdata,
    output logic        fifo_rden,
    output logic        dvp_vsync,
    output logic        dvp_href,
    output logic [7:0]  dvp_data,
    output logic        frame_done,
    output logic        underflow
);

    localparam int LT        = line_total(H_ACTIVE, H_BLANK);
    localparam int ACT_BYTES = 2 * H_ACTIVE;

    function automatic int state_len(input dvp_state_e s);
        case (s)
            VSYNC:   return VSYNC_LINES;
            VBACK:   return V_BACK;
            ACTIVE:  return V_ACTIVE;
            VFRONT:  return V_FRONT;
            default: return 0;
        endcase
    endfunction

    // First state at or after s that has a non-zero line count; IDLE means end of frame.
    function automatic dvp_state_e skip_from(input dvp_state_e s);
        dvp_state_e r;
        r = s;
        if (r == VSYNC  && VSYNC_LINES == 0) r = VBACK;
        if (r == VBACK  && V_BACK == 0)      r = ACTIVE;
        if (r == ACTIVE && V_ACTIVE == 0)    r = VFRONT;
        if (r == VFRONT && V_FRONT == 0)     r = IDLE;
        return r;
    endfunction

    function automatic dvp_state_e next_of(input dvp_state_e s);
        case (s)
            VSYNC:   return skip_from(VBACK);
            VBACK:   return skip_from(ACTIVE);
            ACTIVE:  return skip_from(VFRONT);
            default: return IDLE;
        endcase
    endfunction

    dvp_state_e  state_q;
    logic [HW-1:0] h_q;
    logic [VW-1:0] v_q;
    logic        vsync_q, href_q, frame_done_q, underflow_q;
    logic        cap_q, cap_zero_q;

    dvp_state_e  after_state;
    dvp_state_e  line_state_d;
    logic        line_end, last_line, frame_end;
    logic        active_byte, prefetch, inline_rd, rd_want, load_word;

    // Decode line/frame boundaries, the state of the following line and the read/load strobes.
    always_comb begin
        line_end     = (h_q == HW'(LT - 1));
        last_line    = (v_q == VW'(state_len(state_q) - 1));
        after_state  = next_of(state_q);
        frame_end    = (state_q != IDLE) && line_end && last_line && (after_state == IDLE);
        line_state_d = state_q;
        if (last_line) begin
            if (after_state == IDLE) begin
                line_state_d = enable ? skip_from(VSYNC) : IDLE;
            end else begin
                line_state_d = after_state;
            end
        end
        active_byte = (state_q == ACTIVE) && (h_q < HW'(ACT_BYTES));
        // The first word of an active line is fetched near the end of the preceding line.
        prefetch    = (state_q != IDLE) && (h_q == HW'(LT - 2)) && (line_state_d == ACTIVE);
        inline_rd   = active_byte && (h_q < HW'(ACT_BYTES - BYTES_PER_WORD)) && (h_q[2:0] == 3'd6);
        rd_want     = prefetch || inline_rd;
        load_word   = active_byte && (h_q[2:0] == 3'd0);
    end

    // An empty FIFO suppresses the strobe; the serializer substitutes zeros instead.
    assign fifo_rden = rd_want && !fifo_empty;

    // Timing FSM with registered DVP outputs, so vsync/href/data share one cycle of delay.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            h_q          <= '0;
            v_q          <= '0;
            vsync_q      <= 1'b0;
            href_q       <= 1'b0;
            frame_done_q <= 1'b0;
            underflow_q  <= 1'b0;
            cap_q        <= 1'b0;
            cap_zero_q   <= 1'b0;
        end else begin
            cap_q        <= rd_want;
            cap_zero_q   <= rd_want && fifo_empty;
            vsync_q      <= (state_q == VSYNC);
            href_q       <= active_byte;
            frame_done_q <= frame_end;
            if (rd_want && fifo_empty) begin
                underflow_q <= 1'b1;
            end
            if (state_q == IDLE) begin
                h_q <= '0;
                v_q <= '0;
                if (enable) begin
                    state_q <= skip_from(VSYNC);
                end
            end else if (line_end) begin
                h_q <= '0;
                if (last_line) begin
                    v_q     <= '0;
                    state_q <= line_state_d;
                end else begin
                    v_q <= v_q + 1'b1;
                end
            end else begin
                h_q <= h_q + 1'b1;
            end
        end
    end

    assign dvp_vsync  = vsync_q;
    assign dvp_href   = href_q;
    assign frame_done = frame_done_q;
    assign underflow  = underflow_q;

    dvp_word_serializer u_ser (
        .clk       (clk),
        .rst       (rst),
        .capture_i (cap_q),
        .zero_i    (cap_zero_q),
        .load_i    (load_word),
        .shift_i   (active_byte),
        .word_i    (fifo_rdata),
        .href_i    (href_q),
        .data_o    (dvp_data)
    );

endmodule

// File: tb/tb_dvp_frame_tx.sv
// Directed bench: small-frame timing, byte order, underflow, reset and V_BACK=0 variant.
module tb_dvp_frame_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        fifo_empty = 1'b0;
    logic [63:0] fifo_rdata = '0;
    logic        fifo_rden, dvp_vsync, dvp_href, frame_done, underflow;
    logic [7:0]  dvp_data;

    logic        enable_b = 1'b0;
    logic        empty_b = 1'b0;
    logic [63:0] rdata_b = '0;
    logic        rden_b, vsync_b, href_b, done_b, uf_b;
    logic [7:0]  data_b;

    int total = 0;
    int bad = 0;
    int t = 0;
    bit uf_exp = 1'b0;

    logic [3:0] rd_ptr = '0;
    logic [3:0] rd_ptr_b = '0;
    int rden_cnt = 0;
    int rden_cnt_b = 0;
    int hb_cnt = 0;
    logic [7:0] byte_log [0:1023];

    always #5 clk = ~clk;

    dvp_frame_tx #(
        .H_ACTIVE(8), .V_ACTIVE(2), .H_BLANK(4), .VSYNC_LINES(1),
        .V_BACK(1), .V_FRONT(1), .HW(12), .VW(11)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty),
        .fifo_rdata(fifo_rdata), .fifo_rden(fifo_rden), .dvp_vsync(dvp_vsync),
        .dvp_href(dvp_href), .dvp_data(dvp_data), .frame_done(frame_done),
        .underflow(underflow)
    );

    dvp_frame_tx #(
        .H_ACTIVE(8), .V_ACTIVE(2), .H_BLANK(4), .VSYNC_LINES(1),
        .V_BACK(0), .V_FRONT(1), .HW(12), .VW(11)
    ) dut_b (
        .clk(clk), .rst(rst), .enable(enable_b), .fifo_empty(empty_b),
        .fifo_rdata(rdata_b), .fifo_rden(rden_b), .dvp_vsync(vsync_b),
        .dvp_href(href_b), .dvp_data(data_b), .frame_done(done_b),
        .underflow(uf_b)
    );

    function automatic logic [63:0] word_of(input logic [3:0] k);
        logic [63:0] base;
        logic [63:0] inc;
        base = 64'h0011223344556677;
        inc  = 64'h0808080808080808;
        return base + inc * {60'h0, k};
    endfunction

    function automatic logic [7:0] byte_of(input logic [3:0] k, input int j);
        logic [63:0] w;
        w = word_of(k);
        return w[63 - 8 * j -: 8];
    endfunction

    // FIFO models (1-cycle read latency) and output loggers.
    always @(posedge clk) begin
        if (fifo_rden) begin
            fifo_rdata <= word_of(rd_ptr);
            rd_ptr     <= rd_ptr + 4'd1;
            rden_cnt   <= rden_cnt + 1;
        end
        if (rden_b) begin
            rdata_b    <= word_of(rd_ptr_b);
            rd_ptr_b   <= rd_ptr_b + 4'd1;
            rden_cnt_b <= rden_cnt_b + 1;
        end
        if (dvp_href) begin
            byte_log[hb_cnt % 1024] <= dvp_data;
            hb_cnt <= hb_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h at t=%0d", tag, obs, exp, t);
        end
    endtask

    task automatic goto(input int k);
        while (t < k) begin
            @(negedge clk);
            t++;
        end
    endtask

    // One full frame of the small configuration; t=0 is the first VSYNC cycle.
    task automatic run_frame(input logic [3:0] w_base, input bit uf, input bit drop_en);
        int rd0;
        int hb0;
        logic [3:0] k;
        logic [7:0] eb;
        goto(0);
        rd0 = rden_cnt;
        hb0 = hb_cnt;
        chk("vsync_c0", dvp_vsync, 0);
        chk("uf_c0", underflow, uf_exp);
        goto(1);   chk("vsync_c1", dvp_vsync, 1); chk("href_c1", dvp_href, 0);
        goto(20);  chk("vsync_c20", dvp_vsync, 1);
        goto(21);  chk("vsync_c21", dvp_vsync, 0);
        goto(37);  chk("rden_c37", fifo_rden, 0);
        goto(38);  chk("rden_prefetch", fifo_rden, 1);
        goto(40);  chk("href_c40", dvp_href, 0);
        goto(41);  chk("href_c41", dvp_href, 1); chk("data_c41", dvp_data, byte_of(w_base, 0));
        if (drop_en) begin
            goto(50);
            enable = 1'b0;
        end
        goto(56);  chk("href_c56", dvp_href, 1);
        goto(57);  chk("href_c57", dvp_href, 0); chk("data_c57", dvp_data, 0);
        goto(61);  chk("href_c61", dvp_href, 1);
        if (uf) begin
            goto(65);
            fifo_empty = 1'b1;
            goto(66);  chk("rden_uf", fifo_rden, 0);
            goto(67);
            fifo_empty = 1'b0;
            uf_exp = 1'b1;
            chk("uf_set", underflow, 1);
        end
        goto(76);  chk("href_c76", dvp_href, 1);
        goto(77);  chk("href_c77", dvp_href, 0);
        goto(99);  chk("done_c99", frame_done, 0);
        goto(100); chk("done_c100", frame_done, 1);
        chk("uf_end", underflow, uf_exp);
        chk("bytes_cnt", hb_cnt - hb0, 32);
        chk("rden_cnt", rden_cnt - rd0, uf ? 3 : 4);
        for (int i = 0; i < 32; i++) begin
            k = w_base + 4'((i / 16) * 2 + (i % 16) / 8);
            eb = (uf && i >= 24) ? 8'h00 : byte_of(k, i % 8);
            chk($sformatf("byte%0d", i), byte_log[(hb0 + i) % 1024], eb);
        end
    endtask

    task automatic start_frame();
        @(negedge clk);
        enable = 1'b1;
        t = -1;
    endtask

    initial begin
        int rc;
        repeat (2) @(negedge clk);
        chk("rst_vsync", dvp_vsync, 0);
        chk("rst_href", dvp_href, 0);
        chk("rst_data", dvp_data, 0);
        chk("rst_rden", fifo_rden, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_uf", underflow, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_vsync", dvp_vsync, 0);
        chk("idle_rden", fifo_rden, 0);

        // Frame A: enable pulsed for one cycle -> exactly one frame.
        start_frame();
        goto(0);
        enable = 1'b0;
        run_frame(4'd0, 1'b0, 1'b0);
        rc = rden_cnt;
        goto(130);
        chk("idleA_vsync", dvp_vsync, 0);
        chk("idleA_href", dvp_href, 0);
        chk("idleA_rden", rden_cnt, rc);

        // Frame B: underflow on the second word of line 1, enable dropped mid-ACTIVE.
        start_frame();
        run_frame(4'd4, 1'b1, 1'b1);
        goto(130);
        chk("idleB_vsync", dvp_vsync, 0);

        // Frames C and D back-to-back with enable held; D drops enable mid-frame.
        start_frame();
        run_frame(4'd7, 1'b0, 1'b0);
        t = t - 100;
        run_frame(4'd11, 1'b0, 1'b1);
        rc = rden_cnt;
        goto(130);
        chk("idleD_vsync", dvp_vsync, 0);
        chk("idleD_rden", rden_cnt, rc);

        // Frame E: reset at active byte 5 of the first line.
        start_frame();
        goto(46);
        chk("E_href_b5", dvp_href, 1);
        rst = 1'b1;
        enable = 1'b0;
        #1;
        uf_exp = 1'b0;
        chk("mrst_vsync", dvp_vsync, 0);
        chk("mrst_href", dvp_href, 0);
        chk("mrst_data", dvp_data, 0);
        chk("mrst_rden", fifo_rden, 0);
        chk("mrst_done", frame_done, 0);
        chk("mrst_uf", underflow, 0);
        goto(48);
        rst = 1'b0;
        rc = rden_cnt;
        goto(80);
        chk("post_rst_rden", rden_cnt, rc);
        chk("post_rst_vsync", dvp_vsync, 0);

        // Frame F: clean restart after reset.
        start_frame();
        goto(0);
        enable = 1'b0;
        run_frame(4'd0, 1'b0, 1'b0);

        // V_BACK=0 variant: ACTIVE follows the VSYNC line directly.
        @(negedge clk);
        enable_b = 1'b1;
        t = -1;
        goto(0);
        enable_b = 1'b0;
        goto(1);  chk("B_vsync_c1", vsync_b, 1);
        goto(17); chk("B_rden_c17", rden_b, 0);
        goto(18); chk("B_rden_c18", rden_b, 1);
        goto(20); chk("B_href_c20", href_b, 0); chk("B_vsync_c20", vsync_b, 1);
        goto(21); chk("B_href_c21", href_b, 1); chk("B_data_c21", data_b, 8'h00);
                  chk("B_vsync_c21", vsync_b, 0);
        goto(22); chk("B_data_c22", data_b, 8'h11);
        goto(79); chk("B_done_c79", done_b, 0);
        goto(80); chk("B_done_c80", done_b, 1);
        chk("B_rden_cnt", rden_cnt_b, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
